// File: rtl/game_timer_bcd.sv
// Basketball game clock: MM:SS BCD countdown with a 1 Hz time base,
// start/pause and reload-to-preset keys, and an expiry flag and pulse.
module game_timer_bcd #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PRESET_MIN = 12,
    parameter int PRESET_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_load,
    output logic [3:0] data3,
    output logic [3:0] data2,
    output logic [3:0] data1,
    output logic [3:0] data0,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
    localparam logic [15:0] PRESET_BCD = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
                                          4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10)};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_nxt;
    logic             start_hist, load_hist;
    logic             start_press, load_press;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      time_bcd;
    logic             tick, expire;

    // BCD borrow chain: SS wraps 00 -> 59, borrowing into the minutes.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        logic       b;
        {m10, m1, s10, s1} = t;
        b = (s1 == 4'd0);
        s1 = b ? 4'd9 : s1 - 4'd1;
        if (b) begin
            b = (s10 == 4'd0);
            s10 = b ? 4'd5 : s10 - 4'd1;
            if (b) begin
                b = (m1 == 4'd0);
                m1 = b ? 4'd9 : m1 - 4'd1;
                if (b)
                    m10 = m10 - 4'd1;
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign start_press = key_start & ~start_hist;
    assign load_press  = key_load & ~load_hist;
    assign tick        = (state == RUN) && (div_cnt == DIV_MAX) && !load_press;
    assign expire      = tick && (time_bcd == 16'h0001);

    always_comb begin
        state_nxt = state;
        if (load_press) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_press) state_nxt = (time_bcd == 16'h0000) ? DONE : RUN;
                RUN:     if (expire) state_nxt = DONE;
                         else if (start_press) state_nxt = PAUSE;
                PAUSE:   if (start_press) state_nxt = RUN;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_hist <= 1'b0;
            load_hist  <= 1'b0;
            div_cnt    <= '0;
            time_bcd   <= PRESET_BCD;
            running    <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            start_hist <= key_start;
            load_hist  <= key_load;
            running    <= (state_nxt == RUN);
            done       <= (state_nxt == DONE);
            done_pulse <= (state_nxt == DONE) && (state != DONE);
            if (load_press) begin
                div_cnt  <= '0;
                time_bcd <= PRESET_BCD;
            end else if (state == RUN) begin
                // Divider only advances in RUN, so PAUSE keeps the partial second.
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick)
                    time_bcd <= bcd_dec(time_bcd);
            end
        end
    end

    assign {data3, data2, data1, data0} = time_bcd;

endmodule

// File: tb/tb_game_timer_bcd.sv
// Directed bench for game_timer_bcd: four instances with different presets.
module tb_game_timer_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ks_a = 0, kl_a = 0, ks_b = 0, kl_b = 0, ks_c = 0, kl_c = 0, ks_z = 0, kl_z = 0;
    logic [3:0] a3, a2, a1, a0, b3, b2, b1, b0, c3, c2, c1, c0, z3, z2, z1, z0;
    logic run_a, done_a, dp_a, run_b, done_b, dp_b, run_c, done_c, dp_c, run_z, done_z, dp_z;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_timer_bcd #(.CLK_HZ(4), .PRESET_MIN(12), .PRESET_SEC(0)) u_a (
        .clk(clk), .rst(rst), .key_start(ks_a), .key_load(kl_a),
        .data3(a3), .data2(a2), .data1(a1), .data0(a0),
        .running(run_a), .done(done_a), .done_pulse(dp_a));
    game_timer_bcd #(.CLK_HZ(4), .PRESET_MIN(10), .PRESET_SEC(0)) u_b (
        .clk(clk), .rst(rst), .key_start(ks_b), .key_load(kl_b),
        .data3(b3), .data2(b2), .data1(b1), .data0(b0),
        .running(run_b), .done(done_b), .done_pulse(dp_b));
    game_timer_bcd #(.CLK_HZ(4), .PRESET_MIN(0), .PRESET_SEC(3)) u_c (
        .clk(clk), .rst(rst), .key_start(ks_c), .key_load(kl_c),
        .data3(c3), .data2(c2), .data1(c1), .data0(c0),
        .running(run_c), .done(done_c), .done_pulse(dp_c));
    game_timer_bcd #(.CLK_HZ(4), .PRESET_MIN(0), .PRESET_SEC(0)) u_z (
        .clk(clk), .rst(rst), .key_start(ks_z), .key_load(kl_z),
        .data3(z3), .data2(z2), .data1(z1), .data0(z0),
        .running(run_z), .done(done_z), .done_pulse(dp_z));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_val("rst_digits_a", {a3, a2, a1, a0}, 32'h1200);
        check_val("rst_running_a", run_a, 0);
        check_val("rst_done_a", done_a, 0);
        check_val("rst_dpulse_a", dp_a, 0);
        check_val("rst_digits_c", {c3, c2, c1, c0}, 32'h0003);

        // start, then two whole seconds
        ks_a = 1; step(1); ks_a = 0;
        check_val("start_running", run_a, 1);
        step(3);
        check_val("pre_tick", {a3, a2, a1, a0}, 32'h1200);
        step(1);
        check_val("tick1_1159", {a3, a2, a1, a0}, 32'h1159);
        step(4);
        check_val("tick2_1158", {a3, a2, a1, a0}, 32'h1158);

        // pause with two counts of the next second already done
        step(1);
        ks_a = 1; step(1); ks_a = 0;
        check_val("pause_running", run_a, 0);
        step(20);
        check_val("pause_hold_digits", {a3, a2, a1, a0}, 32'h1158);
        ks_a = 1; step(1); ks_a = 0;
        check_val("resume_running", run_a, 1);
        step(1);
        check_val("resume_no_tick_yet", {a3, a2, a1, a0}, 32'h1158);
        step(1);
        check_val("resume_tick_1157", {a3, a2, a1, a0}, 32'h1157);

        // load and start together while running: load wins
        step(1);
        kl_a = 1; ks_a = 1; step(1);
        check_val("both_keys_digits", {a3, a2, a1, a0}, 32'h1200);
        check_val("both_keys_running", run_a, 0);
        check_val("both_keys_done", done_a, 0);
        kl_a = 0; ks_a = 0; step(1);

        // held start: one transition, then 12 seconds elapse over 50 edges
        ks_a = 1; step(50);
        check_val("held_running", run_a, 1);
        check_val("held_digits_1148", {a3, a2, a1, a0}, 32'h1148);
        ks_a = 0; step(1);
        check_val("held_release_running", run_a, 1);

        // load mid-second discards the partial count
        kl_a = 1; step(1); kl_a = 0;
        check_val("load_digits", {a3, a2, a1, a0}, 32'h1200);
        check_val("load_running", run_a, 0);
        ks_a = 1; step(1); ks_a = 0;
        step(2);
        check_val("load_div_cleared", {a3, a2, a1, a0}, 32'h1200);
        step(2);
        check_val("load_full_second", {a3, a2, a1, a0}, 32'h1159);

        // 10:00 minute borrow
        ks_b = 1; step(1); ks_b = 0;
        step(3);
        check_val("b_pre_tick", {b3, b2, b1, b0}, 32'h1000);
        step(1);
        check_val("b_borrow_0959", {b3, b2, b1, b0}, 32'h0959);

        // expiry from 00:03
        ks_c = 1; step(1); ks_c = 0;
        step(4);
        check_val("c_0002", {c3, c2, c1, c0}, 32'h0002);
        step(4);
        check_val("c_0001", {c3, c2, c1, c0}, 32'h0001);
        step(3);
        check_val("c_pre_expire_done", done_c, 0);
        check_val("c_pre_expire_pulse", dp_c, 0);
        step(1);
        check_val("c_0000", {c3, c2, c1, c0}, 32'h0000);
        check_val("c_done", done_c, 1);
        check_val("c_pulse", dp_c, 1);
        check_val("c_running", run_c, 0);
        step(1);
        check_val("c_pulse_one_cycle", dp_c, 0);
        check_val("c_done_holds", done_c, 1);
        ks_c = 1; step(1); ks_c = 0;
        step(8);
        check_val("c_start_ignored_done", done_c, 1);
        check_val("c_start_ignored_run", run_c, 0);
        check_val("c_stays_0000", {c3, c2, c1, c0}, 32'h0000);
        kl_c = 1; step(1); kl_c = 0;
        check_val("c_load_digits", {c3, c2, c1, c0}, 32'h0003);
        check_val("c_load_done", done_c, 0);
        check_val("c_load_running", run_c, 0);

        // zero preset: start goes straight to DONE
        ks_z = 1; step(1); ks_z = 0;
        check_val("z_done", done_z, 1);
        check_val("z_pulse", dp_z, 1);
        check_val("z_running", run_z, 0);
        check_val("z_digits", {z3, z2, z1, z0}, 32'h0000);
        step(1);
        check_val("z_pulse_one_cycle", dp_z, 0);
        check_val("z_done_holds", done_z, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
